gdp_sequencer: RTL

GDP_SEQUENCER -- requirements
Module: gdp_sequencer

---
 rtl/gdp_pkg.sv | 22 ++
 rtl/feat_buf.sv | 43 ++++
 rtl/gdp_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/gdp_pkg.sv
// rtl/gdp_pkg.sv - shared types and constants for the gdp scoring sequencer
// Purpose: operand type, default sizing, sequencer state encoding and the
//          most-negative score used to seed the running maximum.
// Ports:   none (package).
package gdp_pkg;

   typedef logic signed [15:0] num;

   localparam int DEF_NUM_DIMS   = 8;
   localparam int DEF_NUM_STATES = 16;

   // Smallest representable score; any real ln_p beats or ties it.
   localparam num NUM_MIN = 16'sh8000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } seq_state_e;

endpackage

// File: rtl/feat_buf.sv
// rtl/feat_buf.sv - feature vector register file
// Purpose: holds one frame's feature vector, NUM_DIMS entries of num.
// Ports:   clk, reset (async, active-high) - clock and reset
//          we / waddr / wdata              - synchronous write port
//          raddr / rdata                   - asynchronous read port
module feat_buf
   import gdp_pkg::*;
#(
   parameter int NUM_DIMS = DEF_NUM_DIMS
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        we,
   input  logic [$clog2(NUM_DIMS)-1:0] waddr,
   input  num                          wdata,
   input  logic [$clog2(NUM_DIMS)-1:0] raddr,
   output num                          rdata
);

   num mem_q [NUM_DIMS];
   num mem_d [NUM_DIMS];

   always_comb begin
      mem_d = mem_q;
      // Addresses past NUM_DIMS-1 exist when NUM_DIMS is not a power of two.
      if (we && (int'(waddr) < NUM_DIMS)) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_DIMS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = (int'(raddr) < NUM_DIMS) ? mem_q[raddr] : '0;

endmodule

// File: rtl/gdp_sequencer.sv
// rtl/gdp_sequencer.sv - streams parameters/features into a gdp and ranks its scores
// Purpose: for each frame, walks every (state, dim) parameter address, presents
//          gdp operands one cycle later, collects one ln_p per state and tracks
//          the best-scoring state.
// Ports:   clk, reset                      - clock, async active-high reset
//          start                           - frame request (honoured in IDLE only)
//          feat_we / feat_addr / feat_data - feature buffer write (IDLE only)
//          param_addr                      - parameter memory address (1-cycle read)
//          param_mean / param_omega / param_k - parameter memory data
//          first_calc / last_calc, x, k, omega, mean - gdp operand stream
//          data_ready / ln_p               - gdp result strobe and value
//          score_valid / score_state / score - per-state result
//          best_state / best_score         - running argmax / maximum
//          busy / done                     - frame activity / completion pulse
module gdp_sequencer
   import gdp_pkg::*;
#(
   parameter int NUM_DIMS   = DEF_NUM_DIMS,
   parameter int NUM_STATES = DEF_NUM_STATES
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic                                   feat_we,
   input  logic [$clog2(NUM_DIMS)-1:0]            feat_addr,
   input  num                                     feat_data,
   output logic [$clog2(NUM_STATES*NUM_DIMS)-1:0] param_addr,
   input  num                                     param_mean,
   input  num                                     param_omega,
   input  num                                     param_k,
   output logic                                   first_calc,
   output logic                                   last_calc,
   output num                                     x,
   output num                                     k,
   output num                                     omega,
   output num                                     mean,
   input  logic                                   data_ready,
   input  num                                     ln_p,
   output logic                                   score_valid,
   output logic [7:0]                             score_state,
   output num                                     score,
   output logic [7:0]                             best_state,
   output num                                     best_score,
   output logic                                   busy,
   output logic                                   done
);

   localparam int DW = $clog2(NUM_DIMS);
   localparam int AW = $clog2(NUM_STATES*NUM_DIMS);

   localparam logic [DW-1:0] LAST_D    = DW'(NUM_DIMS - 1);
   localparam logic [7:0]    LAST_S    = 8'(NUM_STATES - 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_STATES*NUM_DIMS - 1);
   // Result counter needs 9 bits so it can reach 256.
   localparam logic [8:0]    R_FULL    = 9'(NUM_STATES);

   seq_state_e     state_q, state_d;
   logic [DW-1:0]  d_q, d_d;
   logic [7:0]     s_q, s_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [8:0]     r_q, r_d;

   // Operand-cycle pipeline: registered alongside the memory's read latency.
   logic           op_valid_q, op_valid_d;
   logic           first_q, first_d;
   logic           last_q, last_d;
   num             x_q, x_d;
   num             k_q, k_d;

   logic           score_valid_q, score_valid_d;
   num             score_q, score_d;
   logic [7:0]     score_state_q, score_state_d;
   num             best_score_q, best_score_d;
   logic [7:0]     best_state_q, best_state_d;

   logic           accept;
   num             feat_rdata;

   feat_buf #(
      .NUM_DIMS (NUM_DIMS)
   ) u_feat_buf (
      .clk   (clk),
      .reset (reset),
      .we    (feat_we && (state_q == IDLE)),
      .waddr (feat_addr),
      .wdata (feat_data),
      .raddr (d_q),
      .rdata (feat_rdata)
   );

   always_comb begin
      state_d       = state_q;
      d_d           = d_q;
      s_d           = s_q;
      addr_d        = addr_q;
      r_d           = r_q;
      op_valid_d    = 1'b0;
      first_d       = 1'b0;
      last_d        = 1'b0;
      x_d           = '0;
      k_d           = k_q;
      score_valid_d = 1'b0;
      score_d       = score_q;
      score_state_d = score_state_q;
      best_score_d  = best_score_q;
      best_state_d  = best_state_q;

      // Results arrive strictly in state order, so the counter is the index.
      accept = data_ready && (state_q != IDLE) && (r_q != R_FULL);
      if (accept) begin
         score_valid_d = 1'b1;
         score_d       = ln_p;
         score_state_d = r_q[7:0];
         r_d           = r_q + 9'd1;
      end

      // Strict compare so a tie keeps the earlier (lower) state index.
      if (score_valid_q && (score_q > best_score_q)) begin
         best_score_d = score_q;
         best_state_d = score_state_q;
      end

      // k is only valid from memory on the d==0 operand cycle; hold it after.
      if (first_q) begin
         k_d = param_k;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = STREAM;
               d_d          = '0;
               s_d          = '0;
               addr_d       = '0;
               r_d          = '0;
               best_score_d = NUM_MIN;
               best_state_d = '0;
            end
         end
         STREAM: begin
            op_valid_d = 1'b1;
            first_d    = (d_q == '0);
            last_d     = (d_q == LAST_D);
            x_d        = feat_rdata;
            if (d_q == LAST_D) begin
               d_d = '0;
               if (s_q == LAST_S) begin
                  state_d = DRAIN;
               end else begin
                  s_d = s_q + 8'd1;
               end
            end else begin
               d_d = d_q + 1'b1;
            end
            // Address saturates on the final entry rather than wrapping.
            if (addr_q != LAST_ADDR) begin
               addr_d = addr_q + 1'b1;
            end
         end
         DRAIN: begin
            if (r_q == R_FULL) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         d_q           <= '0;
         s_q           <= '0;
         addr_q        <= '0;
         r_q           <= '0;
         op_valid_q    <= 1'b0;
         first_q       <= 1'b0;
         last_q        <= 1'b0;
         x_q           <= '0;
         k_q           <= '0;
         score_valid_q <= 1'b0;
         score_q       <= '0;
         score_state_q <= '0;
         best_score_q  <= NUM_MIN;
         best_state_q  <= '0;
      end else begin
         state_q       <= state_d;
         d_q           <= d_d;
         s_q           <= s_d;
         addr_q        <= addr_d;
         r_q           <= r_d;
         op_valid_q    <= op_valid_d;
         first_q       <= first_d;
         last_q        <= last_d;
         x_q           <= x_d;
         k_q           <= k_d;
         score_valid_q <= score_valid_d;
         score_q       <= score_d;
         score_state_q <= score_state_d;
         best_score_q  <= best_score_d;
         best_state_q  <= best_state_d;
      end
   end

   assign param_addr  = addr_q;
   assign first_calc  = first_q;
   assign last_calc   = last_q;
   assign x           = x_q;
   // Memory data is already aligned to the operand cycle; gate it to 0 elsewhere.
   assign mean        = op_valid_q ? param_mean  : '0;
   assign omega       = op_valid_q ? param_omega : '0;
   assign k           = first_q ? param_k : (op_valid_q ? k_q : '0);
   assign score_valid = score_valid_q;
   assign score       = score_q;
   assign score_state = score_state_q;
   assign best_score  = best_score_q;
   assign best_state  = best_state_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);

endmodule
